// File: rtl/bht_update_queue.sv
// bht_update_queue: circular buffer of resolved-branch updates feeding the
// branch history table's single write port. An update that lands behind a
// queued update for the same PC inherits that entry's post-update counter
// state. A lookup port lets fetch see the pending state of a branch.
module bht_update_queue #(
   parameter  int ADDR_W = 10,
   parameter  int DEPTH  = 4,
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_pc_4,
   input  logic [ADDR_W-1:0] in_pc_remote,
   input  logic [1:0]        in_state_old,
   input  logic              in_taken,
   input  logic              hold,
   output logic              upd_en,
   output logic [ADDR_W-1:0] upd_pc_4,
   output logic [ADDR_W-1:0] upd_pc_remote,
   output logic [1:0]        upd_state_old,
   output logic              upd_taken,
   input  logic [ADDR_W-1:0] look_pc_4,
   output logic              look_hit,
   output logic [1:0]        look_state,
   output logic [CNT_W-1:0]  count
);

   typedef struct packed {
      logic [ADDR_W-1:0] pc_4;
      logic [ADDR_W-1:0] pc_remote;
      logic [1:0]        state_old;
      logic              taken;
   } entry_t;

   // 2-bit counter transition; must stay identical to the table's own update.
   function automatic logic [1:0] nx(input logic [1:0] s, input logic t);
      case (s)
         2'b11:   nx = t ? 2'b11 : 2'b10;
         2'b10:   nx = t ? 2'b11 : 2'b00;
         2'b00:   nx = t ? 2'b10 : 2'b01;
         default: nx = t ? 2'b00 : 2'b01;
      endcase
   endfunction

   entry_t           r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   logic             w_nonempty;
   logic             w_pop;
   logic             w_enq;
   logic             w_look_hit;
   logic [1:0]       w_look_nx;
   logic             w_chain_hit;
   logic [1:0]       w_chain_nx;
   logic [1:0]       w_store_state;
   entry_t           w_head;

   assign w_nonempty = (r_count != '0);
   assign w_pop      = w_nonempty & ~hold;
   assign in_ready   = (r_count < CNT_W'(DEPTH)) | w_pop;
   assign w_enq      = in_valid & in_ready;

   // Walk occupied entries oldest to newest so the newest match wins, for both
   // the fetch lookup key and the enqueue chaining key. A popping head is
   // still occupied this cycle, so it takes part in both searches.
   always_comb begin
      // NOTE: every variable driven here gets a default first so no latch is inferred.
      w_look_hit  = 1'b0;
      w_look_nx   = 2'b00;
      w_chain_hit = 1'b0;
      w_chain_nx  = 2'b00;
      for (int k = 0; k < DEPTH; k++) begin
         logic [PTR_W-1:0] w_idx;
         w_idx = r_head + PTR_W'(k);
         if (CNT_W'(k) < r_count) begin
            if (r_mem[w_idx].pc_4 == look_pc_4) begin
               w_look_hit = 1'b1;
               w_look_nx  = nx(r_mem[w_idx].state_old, r_mem[w_idx].taken);
            end
            if (r_mem[w_idx].pc_4 == in_pc_4) begin
               w_chain_hit = 1'b1;
               w_chain_nx  = nx(r_mem[w_idx].state_old, r_mem[w_idx].taken);
            end
         end
      end
   end

   assign w_store_state = w_chain_hit ? w_chain_nx : in_state_old;
   assign look_hit      = w_look_hit;
   assign look_state    = w_look_nx;

   // Head entry drives the table port; zeroed when empty so reset shows zeros
   // even though the storage itself is never cleared.
   assign w_head        = r_mem[r_head];
   assign upd_en        = w_pop;
   assign upd_pc_4      = w_nonempty ? w_head.pc_4      : '0;
   assign upd_pc_remote = w_nonempty ? w_head.pc_remote : '0;
   assign upd_state_old = w_nonempty ? w_head.state_old : 2'b00;
   assign upd_taken     = w_nonempty ? w_head.taken     : 1'b0;
   assign count         = r_count;

   // Pointer and occupancy bookkeeping; reset discards all queued updates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_enq) r_tail <= r_tail + 1'b1;
         if (w_pop) r_head <= r_head + 1'b1;
         r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_pop);
      end
   end

   // Entry storage written at the tail; a full queue that pops reuses the head slot.
   always_ff @(posedge clk) begin
      // NOTE: storage has no reset; occupancy (head/count) alone decides which entries are valid.
      if (w_enq) begin
         r_mem[r_tail] <= '{pc_4:      in_pc_4,
                            pc_remote: in_pc_remote,
                            state_old: w_store_state,
                            taken:     in_taken};
      end
   end

endmodule

// File: tb/tb_bht_update_queue.sv
// Directed self-checking bench for bht_update_queue (ADDR_W=10, DEPTH=4).
module tb_bht_update_queue;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_pc_4;
   logic [ADDR_W-1:0] in_pc_remote;
   logic [1:0]        in_state_old;
   logic              in_taken;
   logic              hold;
   logic              upd_en;
   logic [ADDR_W-1:0] upd_pc_4;
   logic [ADDR_W-1:0] upd_pc_remote;
   logic [1:0]        upd_state_old;
   logic              upd_taken;
   logic [ADDR_W-1:0] look_pc_4;
   logic              look_hit;
   logic [1:0]        look_state;
   logic [CNT_W-1:0]  count;

   int n_checks = 0;
   int n_errors = 0;

   bht_update_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_pc_4       (in_pc_4),
      .in_pc_remote  (in_pc_remote),
      .in_state_old  (in_state_old),
      .in_taken      (in_taken),
      .hold          (hold),
      .upd_en        (upd_en),
      .upd_pc_4      (upd_pc_4),
      .upd_pc_remote (upd_pc_remote),
      .upd_state_old (upd_state_old),
      .upd_taken     (upd_taken),
      .look_pc_4     (look_pc_4),
      .look_hit      (look_hit),
      .look_state    (look_state),
      .count         (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int v, input int pc, input int rem, input int s, input int t);
      in_valid     = 1'(v);
      in_pc_4      = ADDR_W'(pc);
      in_pc_remote = ADDR_W'(rem);
      in_state_old = 2'(s);
      in_taken     = 1'(t);
   endtask

   initial begin
      rst = 1'b1;
      hold = 1'b0;
      look_pc_4 = '0;
      drive(0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_count",    32'(count),    0);
      check("rst_upd_en",   32'(upd_en),   0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_look_hit", 32'(look_hit), 0);
      check("rst_look_st",  32'(look_state), 0);
      check("rst_upd_pc",   32'(upd_pc_4), 0);
      rst = 1'b0;
      tick();

      // Single update: writes in the cycle after the enqueue edge only.
      drive(1, 'h010, 'h080, 1, 1);
      #1;
      check("single_nobypass", 32'(upd_en), 0);
      tick();
      drive(0, 0, 0, 0, 0);
      #1;
      check("single_en",     32'(upd_en),        1);
      check("single_pc",     32'(upd_pc_4),      'h010);
      check("single_rem",    32'(upd_pc_remote), 'h080);
      check("single_state",  32'(upd_state_old), 1);
      check("single_taken",  32'(upd_taken),     1);
      tick();
      #1;
      check("single_en_off", 32'(upd_en), 0);
      check("single_cnt0",   32'(count),  0);

      // Fill under hold, then release with a 5th presented.
      hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1, 'h100 + i, 'h180 + i, i % 4, i % 2);
         #1;
         check("fill_ready", 32'(in_ready), 1);
         tick();
      end
      drive(1, 'h104, 'h184, 0, 0);
      #1;
      check("full_ready", 32'(in_ready), 0);
      check("full_cnt",   32'(count),    4);
      check("full_hold",  32'(upd_en),   0);
      tick();
      #1;
      check("full_cnt2",  32'(count),    4);
      hold = 1'b0;
      #1;
      check("rel_ready",  32'(in_ready), 1);
      check("rel_en",     32'(upd_en),   1);
      check("rel_pc",     32'(upd_pc_4), 'h100);
      tick();
      drive(0, 0, 0, 0, 0);
      #1;
      check("rel_cnt",    32'(count),    4);
      for (int j = 1; j < 5; j++) begin
         check("fifo_en",    32'(upd_en),        1);
         check("fifo_pc",    32'(upd_pc_4),      'h100 + j);
         check("fifo_rem",   32'(upd_pc_remote), 'h180 + j);
         check("fifo_state", 32'(upd_state_old), j % 4);
         check("fifo_taken", 32'(upd_taken),     j % 2);
         tick();
         #1;
      end
      check("fifo_cnt0", 32'(count), 0);

      // Chaining on the same PC.
      hold = 1'b1;
      drive(1, 'h020, 'h0A0, 0, 1);
      #1;
      tick();
      drive(1, 'h020, 'h0A0, 0, 1);
      look_pc_4 = 10'h020;
      #1;
      check("chain_look1_hit", 32'(look_hit),   1);
      check("chain_look1_st",  32'(look_state), 2);
      tick();
      drive(0, 0, 0, 0, 0);
      #1;
      check("chain_look2_st",  32'(look_state), 3);
      check("chain_cnt",       32'(count),      2);
      hold = 1'b0;
      #1;
      check("chain_st0", 32'(upd_state_old), 0);
      tick();
      check("chain_en1", 32'(upd_en),        1);
      check("chain_st1", 32'(upd_state_old), 2);
      tick();
      check("chain_cnt0", 32'(count), 0);

      // Lookup: newest match wins, miss gives 00, popping head still counts.
      hold = 1'b1;
      drive(1, 'h030, 'h0B0, 3, 0);
      #1;
      tick();
      drive(1, 'h030, 'h0B0, 2, 0);
      #1;
      tick();
      drive(0, 0, 0, 0, 0);
      look_pc_4 = 10'h030;
      #1;
      check("look_hit",     32'(look_hit),   1);
      check("look_st",      32'(look_state), 0);
      look_pc_4 = 10'h034;
      #1;
      check("look_miss",    32'(look_hit),   0);
      check("look_miss_st", 32'(look_state), 0);
      look_pc_4 = 10'h030;
      hold = 1'b0;
      #1;
      check("look_drain_st0", 32'(upd_state_old), 3);
      tick();
      check("look_pop_hit",   32'(look_hit),      1);
      check("look_pop_st",    32'(look_state),    0);
      check("look_drain_st1", 32'(upd_state_old), 2);
      tick();
      check("look_empty_hit", 32'(look_hit), 0);

      // Chaining onto a head that pops in the same cycle.
      drive(1, 'h050, 'h0C0, 1, 1);
      #1;
      tick();
      drive(1, 'h050, 'h0C0, 1, 1);
      #1;
      check("popchain_ready", 32'(in_ready),      1);
      check("popchain_st0",   32'(upd_state_old), 1);
      tick();
      drive(0, 0, 0, 0, 0);
      #1;
      check("popchain_en",    32'(upd_en),        1);
      check("popchain_st1",   32'(upd_state_old), 0);
      tick();

      // Back-to-back stream; pointers wrap three times.
      for (int i = 0; i < 12; i++) begin
         drive(1, 'h200 + i, 'h300 + i, i % 4, i % 2);
         #1;
         check("strm_ready", 32'(in_ready), 1);
         check("strm_cnt_le1", 32'(count <= 1), 1);
         if (i > 0) begin
            check("strm_en",    32'(upd_en),        1);
            check("strm_pc",    32'(upd_pc_4),      'h200 + i - 1);
            check("strm_rem",   32'(upd_pc_remote), 'h300 + i - 1);
            check("strm_state", 32'(upd_state_old), (i - 1) % 4);
            check("strm_taken", 32'(upd_taken),     (i - 1) % 2);
         end
         tick();
      end
      drive(0, 0, 0, 0, 0);
      #1;
      check("strm_last_pc", 32'(upd_pc_4), 'h20B);
      check("strm_last_en", 32'(upd_en),   1);
      tick();
      check("strm_cnt0", 32'(count), 0);

      // Asynchronous reset with three entries queued.
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1, 'h400 + i, 'h3F0, 0, 1);
         #1;
         tick();
      end
      drive(0, 0, 0, 0, 0);
      #1;
      check("rstmid_cnt3", 32'(count), 3);
      hold = 1'b0;
      #1;
      check("rstmid_en_pre", 32'(upd_en), 1);
      rst = 1'b1;
      #1;
      check("rstmid_cnt0",  32'(count),    0);
      check("rstmid_en0",   32'(upd_en),   0);
      check("rstmid_ready", 32'(in_ready), 1);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("post_rst_en", 32'(upd_en), 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bht_update_queue.md
# bht_update_queue

Buffers resolved-branch updates from the execute stage and feeds them one per cycle into the branch history table's single update port. Later updates to the same branch are chained onto still-queued ones: an update enqueued behind a pending one for the same PC inherits that entry's post-update state instead of the stale state it carried since fetch. It also exposes a lookup port so fetch can see the pending state of a branch before the table is written. The block sits between the execute stage and the table's update_en / update_* inputs.

## Interface
- ADDR_W, 10: instruction address width (pc_4 / remote target).
- DEPTH, 4: queue entries; power of two, at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  execute stage presents a resolved branch.
- in_ready  out  1  queue accepts this cycle.
- in_pc_4  in  ADDR_W  branch PC+4 (table key).
- in_pc_remote  in  ADDR_W  taken target.
- in_state_old  in  2  2-bit counter state read at fetch.
- in_taken  in  1  actual outcome.
- hold  in  1  suppresses draining; enqueue is unaffected.
- upd_en  out  1  table write strobe; the table writes at the edge that ends the cycle.
- upd_pc_4, upd_pc_remote  out  ADDR_W  head entry fields.
- upd_state_old  out  2  head entry's state_old.
- upd_taken  out  1  head entry's outcome.
- look_pc_4  in  ADDR_W  fetch query key.
- look_hit  out  1  some queued entry matches look_pc_4.
- look_state  out  2  predicted state after the newest matching entry.
- count  out  clog2(DEPTH+1)  occupancy.

## Operation
- Counter transition nx(s,t), identical to the table's: with t=1, 11→11, 10→11, 00→10, 01→00; with t=0, 11→10, 10→00, 00→01, 01→01.
- Storage is a circular buffer of DEPTH entries {pc_4, pc_remote, state_old, taken} with head and tail pointers that wrap modulo DEPTH, plus a count.
- Drain: upd_en = (count≠0) & ~hold. The upd_* outputs always show the head entry; their values are don't-care when count=0. When upd_en is high, the head pops at the clock edge.
- Enqueue: fires when in_valid & in_ready. in_ready = (count<DEPTH) | upd_en, so a full queue accepts only if the head pops in the same cycle.
- State chaining on enqueue:
  - Search all currently occupied entries, including a head popping this cycle, for pc_4 == in_pc_4.
  - If any match, the newest match (closest to tail) with fields s,t sets the stored state_old = nx(s,t).
  - Otherwise the stored state_old = in_state_old.
  - pc_remote and taken are stored unmodified.
- Lookup is combinational over occupied entries. The newest match with fields s,t gives look_hit=1 and look_state=nx(s,t). With no match, look_hit=0 and look_state=00. A head popping this cycle still counts as occupied.
- Simultaneous enqueue and pop: count is unchanged, and both pointers advance.
- Reset at any time drops every queued update without writing it. Lost updates are acceptable because they only degrade prediction.

## Timing
- Reset values: count=0, upd_en=0, in_ready=1, look_hit=0, look_state=00, upd_* =0; head and tail pointers = 0.
- Enqueue-to-write latency:
  - An entry enqueued at edge N can drive upd_en in cycle N+1 at the earliest, and only if it is at the head and hold=0.
  - There is no same-cycle bypass from the in_* inputs to the upd_* outputs.
- upd_en and the upd_* outputs are combinational from registers only; they do not depend on in_* or look_*.
- look_hit and look_state depend combinationally on look_pc_4 and on registers only.
- in_ready depends combinationally on count and hold only.
- Throughput is one enqueue and one drain per cycle.

## Test plan
- Reset, then single update pc_4=0x010, remote=0x080, state_old=01, taken=1 with hold=0 → upd_en high for exactly the cycle after the enqueue edge, with upd_state_old=01, upd_taken=1; count returns to 0.
- hold=1 while enqueuing 5 distinct updates with DEPTH=4 → in_ready drops after the 4th and count=4. Release hold with the 5th still asserted → 5th accepted on the first drain cycle; outputs drain in FIFO order over 5 consecutive cycles.
- Chaining: hold=1, enqueue pc_4=0x020 (state_old=00, taken=1), then pc_4=0x020 (state_old=00, taken=1) → the second entry stores state_old=10 (nx(00,1)). On drain, upd_state_old is 00 then 10.
- Lookup: queue holds pc_4=0x030 entries (11, t=0) then (10, t=0); look_pc_4=0x030 → look_hit=1, look_state=00. look_pc_4=0x034 → look_hit=0, look_state=00.
- Wrap and simultaneous events: stream 12 updates back-to-back with hold=0, with in_valid every cycle → in_ready stays 1, count ≤1, and pointers wrap at least twice with no loss or reordering.
- Assert rst mid-stream with count=3 → in the same cycle count=0 and upd_en=0. No further writes occur after rst deasserts without new enqueues.
